hiscore_uploader: RTL

- Core-side responder for the HPS ioctl upload direction (core → HPS), the counterpart to the ROM download path.
- When the HPS asserts ioctl_upload, the block pauses the game CPU and reads bytes from a window of game work RAM (hiscore/NVRAM area) on each ioctl_rd strobe.
- Each byte is returned on ioctl_din.
- It sits in emu beside hps_io and borrows the game RAM's second port through a pause/ack handshake.

---
 rtl/hiscore_pkg.sv | 20 ++
 rtl/hiscore_req_buf.sv | 33 +++
 rtl/hiscore_uploader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared types and constants for the hiscore upload responder
package hiscore_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_READY,
        S_FETCH,
        S_CAPTURE
    } state_t;

    localparam logic [7:0] FILL_BYTE = 8'hFF;
    localparam int         IOCTL_AW  = 25;

    // The ack timer only has to count 0 .. timeout-1.
    function automatic int timer_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/hiscore_req_buf.sv
// rtl/hiscore_req_buf.sv - one-entry pending ioctl read latch with overrun detect
module hiscore_req_buf
    import hiscore_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                push,
    input  logic [IOCTL_AW-1:0] push_addr,
    input  logic                pop,
    output logic                valid,
    output logic [IOCTL_AW-1:0] addr,
    output logic                overrun
);

    // A push into a full entry that is not being drained this cycle is lost.
    assign overrun = push & valid & ~pop & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (push && (!valid || pop)) begin
            valid <= 1'b1;
            addr  <= push_addr;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hiscore_uploader.sv
// rtl/hiscore_uploader.sv - serves HPS ioctl upload reads from a paused game RAM window
module hiscore_uploader
    import hiscore_pkg::*;
#(
    parameter int              AW          = 11,
    parameter logic [AW-1:0]   BASE        = '0,
    parameter int              SIZE        = 256,
    parameter int              RD_LAT      = 1,
    parameter logic [15:0]     ACK_TIMEOUT = 16'd4096
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_upload,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]          ioctl_din,
    output logic                pause_req,
    input  logic                pause_ack,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_rd,
    input  logic [7:0]          ram_dout,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_overrun
);

    localparam int            TW       = timer_width(int'(ACK_TIMEOUT));
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 16'd1);
    localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);

    state_t              state;
    logic                upload_q;
    logic [TW-1:0]       timer;
    logic [1:0]          lat_cnt;
    logic                fetch_in_range;

    logic                rd_ok;
    logic                pend_valid;
    logic [IOCTL_AW-1:0] pend_addr;
    logic                pend_push;
    logic                pend_pop;
    logic                pend_overrun;
    logic [IOCTL_AW-1:0] req_addr;
    logic                req_in_range;

    assign rd_ok = ioctl_rd & ioctl_upload;

    // In READY a live strobe goes straight to FETCH unless an older request is
    // queued; then the older one is fetched and the new one takes its slot.
    assign pend_pop  = (state == S_READY) & pend_valid;
    assign pend_push = rd_ok & ((state == S_ARM) | (state == S_FETCH) |
                                (state == S_CAPTURE) | pend_pop);

    assign req_addr     = pend_valid ? pend_addr : ioctl_addr;
    assign req_in_range = req_addr < IOCTL_AW'(SIZE);

    assign busy = pend_valid | (state == S_FETCH) | (state == S_CAPTURE);

    hiscore_req_buf u_req_buf (
        .clk       (clk_sys),
        .reset     (reset),
        .clr       (~ioctl_upload),
        .push      (pend_push),
        .push_addr (ioctl_addr),
        .pop       (pend_pop),
        .valid     (pend_valid),
        .addr      (pend_addr),
        .overrun   (pend_overrun)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            upload_q       <= 1'b0;
            timer          <= '0;
            lat_cnt        <= '0;
            fetch_in_range <= 1'b0;
            pause_req      <= 1'b0;
            ram_rd         <= 1'b0;
            ram_addr       <= '0;
            ioctl_din      <= FILL_BYTE;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            ram_rd   <= 1'b0;
            if (pend_overrun)
                err_overrun <= 1'b1;

            if (!ioctl_upload) begin
                state     <= S_IDLE;
                pause_req <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!upload_q) begin
                            state       <= S_ARM;
                            pause_req   <= 1'b1;
                            err_timeout <= 1'b0;
                            err_overrun <= 1'b0;
                            timer       <= '0;
                        end
                    end
                    S_ARM: begin
                        if (pause_ack) begin
                            state <= S_READY;
                        end else if (timer == TMR_LAST) begin
                            state       <= S_READY;
                            err_timeout <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_READY: begin
                        if (rd_ok || pend_valid) begin
                            state          <= S_FETCH;
                            lat_cnt        <= '0;
                            fetch_in_range <= req_in_range;
                            if (req_in_range) begin
                                ram_addr <= BASE + req_addr[AW-1:0];
                                ram_rd   <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (!fetch_in_range) begin
                            ioctl_din <= FILL_BYTE;
                            state     <= S_READY;
                        end else if (lat_cnt == LAT_LAST) begin
                            state <= S_CAPTURE;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end
                    S_CAPTURE: begin
                        ioctl_din <= ram_dout;
                        state     <= S_READY;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
